// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, the default
// RAM word-address width and the byte-enable generator used by stores.
package mem_access_stage_pkg;

  localparam int ADDR_W_DEF = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Lane enables for an access of the given size at the given byte offset.
  // Any size other than byte/half (including 2'b10) is a full word.
  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b1111;
    if (size == SZ_BYTE) begin
      be = 4'b0001 << offset;
    end else if (size == SZ_HALF) begin
      be = offset[1] ? 4'b1100 : 4'b0011;
    end
    return be;
  endfunction

endpackage

// File: rtl/mem_access_stage_data_ram.sv
// Dual-port data RAM for the MEM stage.
// Port A: byte-enable write plus gated synchronous read (read-first).
// Port B: read-only synchronous read (read-first on collision with port A).
// The array has no reset.
//   i_clk     clock
//   i_we_a    per-lane write enables, port A
//   i_re_a    read enable, port A (output register holds when low)
//   i_addr_a  word address, port A
//   i_wdata_a write data, lanes already positioned
//   o_rdata_a registered read word, port A
//   i_addr_b  word address, port B
//   o_rdata_b registered read word, port B
module data_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic [3:0]        i_we_a,
  input  logic              i_re_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [31:0]       i_wdata_a,
  output logic [31:0]       o_rdata_a,
  input  logic [ADDR_W-1:0] i_addr_b,
  output logic [31:0]       o_rdata_b
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we_a[i]) mem_q[i_addr_a][i*8 +: 8] <= i_wdata_a[i*8 +: 8];
    end
    if (i_re_a) o_rdata_a <= mem_q[i_addr_a];
    o_rdata_b <= mem_q[i_addr_b];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: byte/half/word stores and sign/zero-extended loads against the
// internal data RAM, with all results registered into the MEM/WB boundary.
// A second RAM port provides a registered debug read.
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_stall, i_flush          hold MEM/WB / insert bubble
//   i_alu_result, i_store_data byte address or pass-through value, store data
//   i_mem_read, i_mem_write   access type; i_size, i_unsigned access format
//   i_reg_write, i_mem_to_reg, i_rd  WB controls, passed through
//   i_debug_addr              debug word address
//   o_read_data ... o_misaligned     MEM/WB outputs; o_debug_data debug word
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int N        = 32,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int REG_ADDR = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [N-1:0]        i_alu_result,
  input  logic [N-1:0]        i_store_data,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [1:0]          i_size,
  input  logic                i_unsigned,
  input  logic                i_reg_write,
  input  logic                i_mem_to_reg,
  input  logic [REG_ADDR-1:0] i_rd,
  input  logic [ADDR_W-1:0]   i_debug_addr,
  output logic [N-1:0]        o_read_data,
  output logic [N-1:0]        o_alu_result,
  output logic [REG_ADDR-1:0] o_rd,
  output logic                o_reg_write,
  output logic                o_mem_to_reg,
  output logic                o_misaligned,
  output logic [N-1:0]        o_debug_data
);

  logic [1:0]        offset;
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata_a;
  logic [31:0]       ram_rdata_b;

  logic [N-1:0]        alu_q, alu_d;
  logic [REG_ADDR-1:0] rd_q, rd_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic                mis_q, mis_d;
  logic                load_q, load_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          off_q, off_d;
  logic                uns_q, uns_d;
  logic                dbg_valid_q;

  assign offset   = i_alu_result[1:0];
  assign word_idx = i_alu_result[ADDR_W+1:2];

  always_comb begin
    misaligned = (i_mem_read || i_mem_write) &&
                 (((i_size == SZ_HALF) && offset[0]) ||
                  (i_size[1] && (offset != 2'b00)));
    ram_we = i_mem_write && !misaligned && !i_stall && !i_reset;
    ram_be = ram_we ? byte_en(i_size, offset) : 4'b0000;
    case (i_size)
      SZ_BYTE: ram_wdata = {4{i_store_data[7:0]}};
      SZ_HALF: ram_wdata = {2{i_store_data[15:0]}};
      default: ram_wdata = i_store_data[31:0];
    endcase
  end

  // Port A read is gated by stall so the captured word, and thus the
  // formatted o_read_data, holds along with the rest of MEM/WB.
  data_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk     (i_clk),
    .i_we_a    (ram_be),
    .i_re_a    (!i_stall),
    .i_addr_a  (word_idx),
    .i_wdata_a (ram_wdata),
    .o_rdata_a (ram_rdata_a),
    .i_addr_b  (i_debug_addr),
    .o_rdata_b (ram_rdata_b)
  );

  always_comb begin
    alu_d        = alu_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mis_d        = mis_q;
    load_d       = load_q;
    size_d       = size_q;
    off_d        = off_q;
    uns_d        = uns_q;
    if (i_flush) begin
      alu_d        = '0;
      rd_d         = '0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mis_d        = 1'b0;
      load_d       = 1'b0;
      size_d       = 2'b00;
      off_d        = 2'b00;
      uns_d        = 1'b0;
    end else if (!i_stall) begin
      alu_d        = i_alu_result;
      rd_d         = i_rd;
      reg_write_d  = i_reg_write && !misaligned;
      mem_to_reg_d = i_mem_to_reg;
      mis_d        = misaligned;
      // Read+write together is a store: no load data for that slot.
      load_d       = i_mem_read && !i_mem_write && !misaligned;
      size_d       = i_size;
      off_d        = offset;
      uns_d        = i_unsigned;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mis_q        <= 1'b0;
      load_q       <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      uns_q        <= 1'b0;
      dbg_valid_q  <= 1'b0;
    end else begin
      alu_q        <= alu_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mis_q        <= mis_d;
      load_q       <= load_d;
      size_q       <= size_d;
      off_q        <= off_d;
      uns_q        <= uns_d;
      dbg_valid_q  <= 1'b1;
    end
  end

  logic [7:0]   lane;
  logic [15:0]  half;
  logic [N-1:0] read_data;

  always_comb begin
    case (off_q)
      2'd0:    lane = ram_rdata_a[7:0];
      2'd1:    lane = ram_rdata_a[15:8];
      2'd2:    lane = ram_rdata_a[23:16];
      default: lane = ram_rdata_a[31:24];
    endcase
    half      = off_q[1] ? ram_rdata_a[31:16] : ram_rdata_a[15:0];
    read_data = '0;
    if (load_q) begin
      case (size_q)
        SZ_BYTE: read_data = {{24{!uns_q && lane[7]}}, lane};
        SZ_HALF: read_data = {{16{!uns_q && half[15]}}, half};
        default: read_data = ram_rdata_a;
      endcase
    end
  end

  assign o_read_data  = read_data;
  assign o_alu_result = alu_q;
  assign o_rd         = rd_q;
  assign o_reg_write  = reg_write_q;
  assign o_mem_to_reg = mem_to_reg_q;
  assign o_misaligned = mis_q;
  // The RAM output register is not reset; gate it so reset reads as zero.
  assign o_debug_data = dbg_valid_q ? ram_rdata_b : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, mrd, mwr, uns, regw, m2r;
  logic [31:0] alu, sd;
  logic [1:0]  sz;
  logic [4:0]  rd;
  logic [7:0]  dbg;
  logic [31:0] o_read_data, o_alu_result, o_debug_data;
  logic [4:0]  o_rd;
  logic        o_reg_write, o_mem_to_reg, o_misaligned;

  int checks = 0;
  int failures = 0;

  // Reference memory as a flat little-endian byte array.
  logic [7:0]  mb [1024];
  logic [31:0] e_rdata = 0, e_alu = 0, e_dbg = 0;
  logic [4:0]  e_rd = 0;
  logic        e_rw = 0, e_m2r = 0, e_mis = 0;
  logic [31:0] saved;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
    .i_alu_result(alu), .i_store_data(sd), .i_mem_read(mrd),
    .i_mem_write(mwr), .i_size(sz), .i_unsigned(uns), .i_reg_write(regw),
    .i_mem_to_reg(m2r), .i_rd(rd), .i_debug_addr(dbg),
    .o_read_data(o_read_data), .o_alu_result(o_alu_result), .o_rd(o_rd),
    .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
    .o_misaligned(o_misaligned), .o_debug_data(o_debug_data)
  );

  function automatic logic [31:0] mword(input int wi);
    return {mb[wi*4+3], mb[wi*4+2], mb[wi*4+1], mb[wi*4]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    if (!$isunknown(exp)) begin
      checks++;
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input bit r, input bit st, input bit fl,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit rdq, input bit wr, input logic [1:0] s,
                      input bit u, input bit rw, input bit mr,
                      input logic [4:0] dst, input logic [7:0] da);
    int ba;
    bit mis;
    logic [31:0] ld;
    rst = r; stall = st; flush = fl; alu = a; sd = d; mrd = rdq; mwr = wr;
    sz = s; uns = u; regw = rw; m2r = mr; rd = dst; dbg = da;
    ba  = int'(a[9:0]);
    mis = (rdq || wr) && ((s == 2'b01 && a[0]) || (s[1] && a[1:0] != 0));
    if (s == 2'b00)
      ld = u ? {24'h0, mb[ba]} : {{24{mb[ba][7]}}, mb[ba]};
    else if (s == 2'b01)
      ld = u ? {16'h0, mb[ba+1], mb[ba]} : {{16{mb[ba+1][7]}}, mb[ba+1], mb[ba]};
    else
      ld = {mb[(ba+3)%1024], mb[(ba+2)%1024], mb[(ba+1)%1024], mb[ba]};
    if (r) begin
      e_rdata = 0; e_alu = 0; e_rd = 0; e_rw = 0; e_m2r = 0; e_mis = 0; e_dbg = 0;
    end else begin
      e_dbg = mword(int'(da));
      if (fl) begin
        e_rdata = 0; e_alu = 0; e_rd = 0; e_rw = 0; e_m2r = 0; e_mis = 0;
      end else if (!st) begin
        e_alu = a; e_rd = dst; e_rw = rw && !mis; e_m2r = mr; e_mis = mis;
        e_rdata = (rdq && !wr && !mis) ? ld : 32'h0;
      end
    end
    if (wr && !mis && !st && !r) begin
      mb[ba] = d[7:0];
      if (s != 2'b00) mb[ba+1] = d[15:8];
      if (s[1]) begin
        mb[ba+2] = d[23:16];
        mb[ba+3] = d[31:24];
      end
    end
    @(posedge clk);
    #1;
    chk("read_data", o_read_data, e_rdata);
    chk("alu_result", o_alu_result, e_alu);
    chk("rd", {27'h0, o_rd}, {27'h0, e_rd});
    chk("reg_write", {31'h0, o_reg_write}, {31'h0, e_rw});
    chk("mem_to_reg", {31'h0, o_mem_to_reg}, {31'h0, e_m2r});
    chk("misaligned", {31'h0, o_misaligned}, {31'h0, e_mis});
    chk("debug_data", o_debug_data, e_dbg);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                    input bit st, input logic [7:0] da);
    step(0, st, 0, a, d, 0, 1, s, 0, 0, 0, 5'd0, da);
  endtask

  task automatic lw(input logic [31:0] a, input logic [1:0] s, input bit u);
    step(0, 0, 0, a, 32'h0, 1, 0, s, u, 1, 1, 5'd7, 8'd0);
  endtask

  initial begin
    step(1, 0, 0, 32'h0, 32'h0, 0, 0, 2'b11, 0, 0, 0, 5'd0, 8'd0);
    chk("reset_read_data", o_read_data, 32'h0);
    chk("reset_debug", o_debug_data, 32'h0);

    for (int wi = 0; wi < 256; wi++)
      sw(wi * 4, $urandom, 2'b11, 0, 8'(wi));

    // Word store then load.
    sw(32'h10, 32'hDEADBEEF, 2'b11, 0, 8'd0);
    lw(32'h10, 2'b11, 0);
    chk("t1_lw", o_read_data, 32'hDEADBEEF);
    chk("t1_regw", {31'h0, o_reg_write}, 32'h1);

    // Byte lanes and extension.
    sw(32'h20, 32'h0, 2'b11, 0, 8'd0);
    sw(32'h21, 32'h80, 2'b00, 0, 8'd0);
    lw(32'h21, 2'b00, 0);
    chk("t2_lb", o_read_data, 32'hFFFFFF80);
    lw(32'h21, 2'b00, 1);
    chk("t2_lbu", o_read_data, 32'h00000080);
    lw(32'h20, 2'b11, 0);
    chk("t2_lw", o_read_data, 32'h00008000);

    // Half lanes.
    sw(32'h30, 32'h11223344, 2'b11, 0, 8'd0);
    sw(32'h32, 32'h0000BEEF, 2'b01, 0, 8'd0);
    lw(32'h32, 2'b01, 0);
    chk("t3_lh", o_read_data, 32'hFFFFBEEF);
    lw(32'h32, 2'b01, 1);
    chk("t3_lhu", o_read_data, 32'h0000BEEF);
    lw(32'h30, 2'b11, 0);
    chk("t3_lw", o_read_data, 32'hBEEF3344);

    // Misaligned accesses.
    lw(32'h13, 2'b01, 0);
    chk("t4_mis", {31'h0, o_misaligned}, 32'h1);
    chk("t4_regw", {31'h0, o_reg_write}, 32'h0);
    chk("t4_data", o_read_data, 32'h0);
    sw(32'h22, 32'h55, 2'b11, 0, 8'd0);
    chk("t4_sw_mis", {31'h0, o_misaligned}, 32'h1);
    lw(32'h20, 2'b11, 0);
    chk("t4_unchanged", o_read_data, 32'h00008000);

    // Stall suppresses the store and holds outputs; flush clears.
    lw(32'h40, 2'b11, 0);
    saved = o_read_data;
    sw(32'h40, 32'hA5A5A5A5, 2'b11, 1, 8'd0);
    chk("t5_hold", o_read_data, saved);
    lw(32'h40, 2'b11, 0);
    chk("t5_prior", o_read_data, saved);
    step(0, 0, 1, 32'h44, 32'h0, 1, 0, 2'b11, 0, 1, 1, 5'd3, 8'd0);
    chk("t5_flush", o_alu_result, 32'h0);

    // Debug read-first collision, then reset mid-load.
    sw(32'h10, 32'h12345678, 2'b11, 0, 8'd4);
    chk("t6_dbg_old", o_debug_data, 32'hDEADBEEF);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 2'b11, 0, 0, 0, 5'd0, 8'd4);
    chk("t6_dbg_new", o_debug_data, 32'h12345678);
    lw(32'h10, 2'b11, 0);
    step(1, 0, 0, 32'h10, 32'h0, 1, 0, 2'b11, 0, 1, 1, 5'd9, 8'd4);
    chk("t6_reset", o_read_data, 32'h0);
    lw(32'h10, 2'b11, 0);
    chk("t6_after_reset", o_read_data, 32'h12345678);

    // Randomised traffic against the byte model, including address wrap.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a;
      int k;
      a = {$urandom_range(0, 4194303), 10'(0)} | 32'($urandom_range(0, 95));
      k = $urandom_range(0, 3);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0, a, $urandom, k[0], k[1],
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 8'($urandom_range(0, 23)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX-stage ALU. It consumes the ALU result as a byte address (loads/stores) or as a pass-through value (R/I-type ops). It also consumes the store data, and it contains the data RAM. It performs byte/half/word stores and loads with sign or zero extension, and registers everything into the MEM/WB boundary. A second read-only port serves the debug unit.

Parameters:
N, 32, datapath width (fixed at 32 for lane logic)
ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W words
REG_ADDR, 5, register-file index width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_stall  in  1  hold MEM/WB outputs; suppress RAM write
i_flush  in  1  load a bubble into MEM/WB
i_alu_result  in  N  ALU result / byte address
i_store_data  in  N  rt value for stores
i_mem_read  in  1  load in this cycle
i_mem_write  in  1  store in this cycle
i_size  in  2  00 byte, 01 half, 11 word (10 treated as word)
i_unsigned  in  1  zero-extend loads (LBU/LHU)
i_reg_write  in  1  WB enable, passed through
i_mem_to_reg  in  1  WB mux select, passed through
i_rd  in  REG_ADDR  destination register, passed through
i_debug_addr  in  ADDR_W  debug word address
o_read_data  out  N  formatted load data
o_alu_result  out  N  registered i_alu_result
o_rd  out  REG_ADDR  registered i_rd
o_reg_write  out  1  registered WB enable
o_mem_to_reg  out  1  registered select
o_misaligned  out  1  access in this MEM/WB slot was misaligned
o_debug_data  out  N  debug read word

Behaviour:
- Word index = i_alu_result[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo RAM size.
- Byte offset = i_alu_result[1:0]. Lane order is little-endian: offset 0 selects bits 7:0.
- Misaligned access:
  - half access with offset[0]=1, or word access with offset!=0;
  - evaluated only when i_mem_read or i_mem_write is high.
- Store (i_mem_write=1, aligned, !i_stall):
  - written at the rising edge ending the cycle, using byte enables;
  - byte: i_store_data[7:0] goes to the lane at offset;
  - half: i_store_data[15:0] goes to lanes {offset[1],0} and {offset[1],1};
  - word: all four lanes;
  - unselected lanes are unchanged.
- Load:
  - RAM read is synchronous;
  - the word is captured at the edge ending cycle T, together with offset, size and i_unsigned;
  - o_read_data is valid in cycle T+1, formatted from the captured word: lane/half extracted, then sign- or zero-extended, or the word returned as-is.
- Latency: 1 cycle for all outputs.
- A store in cycle T followed by a load to the same word in T+1 returns the new data.
- i_mem_read and i_mem_write both high: treated as a store; o_read_data = 0 for that slot.
- Misaligned slot:
  - no RAM write;
  - o_read_data = 0, o_misaligned = 1, o_reg_write forced 0;
  - other outputs pass through normally.
- Non-memory slot: o_read_data = 0, o_misaligned = 0.
- Output register priority, per edge: i_reset > i_flush > i_stall > load.
  - i_reset or i_flush: all outputs 0.
  - i_stall: all MEM/WB outputs hold their value; no write.
- Reset:
  - all outputs 0, including o_debug_data;
  - RAM contents are not cleared;
  - a store coinciding with reset is suppressed;
  - reset mid-sequence drops the in-flight slot.
- Debug port:
  - o_debug_data = RAM[i_debug_addr] registered with 1-cycle latency, independent of stall/flush;
  - on a same-word collision with a store, it returns the old word that cycle and the new word the next cycle (read-first).

Decomposition:
- Shared package/header holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b11;
  - the byte-enable generation function;
  - ADDR_W default.
- One sub-module, data_ram:
  - true dual port (write+read port A, read-only port B);
  - byte-enable write, read-first, no reset on the array.
- Lane formatting and misalignment logic stay in mem_access_stage.

Test Plan:
1. SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> o_read_data=0xDEADBEEF one cycle later, o_reg_write follows i_reg_write.
2. SW 0 @0x20; SB 0x80 @0x21; LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; LW @0x20 -> 0x00008000.
3. SH 0xBEEF @0x32 onto word 0x11223344; LH @0x32 -> 0xFFFFBEEF; LHU -> 0x0000BEEF; LW @0x30 -> 0xBEEF3344.
4. LH @0x13 -> o_misaligned=1, o_read_data=0, o_reg_write=0; SW 0x55 @0x22 -> o_misaligned=1, LW @0x20 unchanged.
5. SW 0xA5A5A5A5 @0x40 with i_stall=1 -> LW @0x40 returns prior value, outputs held during stall; i_flush=1 -> all outputs 0 next cycle.
6. Debug read word 0x04 while SW 0x12345678 @0x10 -> old value then 0x12345678; assert i_reset mid-load -> outputs 0, LW @0x10 afterwards still returns 0x12345678.
